// File: rtl/imul_share_arbiter_pkg.sv
// Purpose: shared types and constants for the shared-multiplier arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imul_share_arbiter_pkg;

    localparam int OPND_W      = 16;
    localparam int PROD_W      = 32;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/imul_share_arbiter_if.sv
// Purpose: request/operand/result bundle between client units and the arbiter.
// Latency: n/a (wiring only).
// Backpressure: clients hold iReq until granted; the arbiter owns grant/done.
interface imul_share_arbiter_if
    import imul_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) ();

    logic [NUM_REQ-1:0]        iReq;
    logic [NUM_REQ*OPND_W-1:0] iA;
    logic [NUM_REQ*OPND_W-1:0] iB;
    logic [NUM_REQ-1:0]        oGrant;
    logic [NUM_REQ-1:0]        oDone;
    logic [PROD_W-1:0]         oResult;
    logic                      oBusy;

    // Client side: drives requests and operands.
    modport master (
        output iReq, iA, iB,
        input  oGrant, oDone, oResult, oBusy
    );

    // Arbiter side.
    modport slave (
        input  iReq, iA, iB,
        output oGrant, oDone, oResult, oBusy
    );

endinterface

// File: rtl/imul_share_arbiter_rr_picker.sv
// Purpose: round-robin pick of the first set request at or above the pointer.
// Latency: combinational.
// Backpressure: none; an empty request vector yields an all-zero winner.
module imul_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o
);

    // Scan upward from the pointer, wrapping, and stop at the first request.
    always_comb begin : pick
        int   k;
        logic found;
        k     = 0;
        found = 1'b0;
        gnt_o = '0;
        idx_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(ptr_i) + i) % NUM_REQ;
            if (!found && req_i[k]) begin
                found    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/imul_share_arbiter.sv
// Purpose: shares one 16x16 unsigned multiplier among NUM_REQ clients, round-robin
//          (fixed priority, requester 0 first, when IMUL_ARB_FIXED_PRIO_EN is defined).
// Latency: request sampled at edge t -> oGrant from t+1, oDone/oResult in cycle t+LATENCY+1.
// Backpressure: one operation at a time; requests are only sampled in IDLE, never queued.
module imul_share_arbiter
    import imul_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic Clock,
    input  logic Reset,
    imul_share_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    arb_state_t          state_q,  state_d;
    logic [IDX_W-1:0]    ptr_q,    ptr_d;
    logic [IDX_W-1:0]    win_q,    win_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [NUM_REQ-1:0]  grant_q,  grant_d;
    logic [OPND_W-1:0]   op_a_q,   op_a_d;
    logic [OPND_W-1:0]   op_b_q,   op_b_d;
    logic [PROD_W-1:0]   result_q, result_d;

    logic [NUM_REQ-1:0]  pick_gnt;
    logic [IDX_W-1:0]    pick_idx;
    logic [PROD_W-1:0]   product;

    imul_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i (bus.iReq),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    // Shared array multiplier; operands are registered, so it only has to settle
    // within the LATENCY cycles spent in WAIT.
    assign product = PROD_W'(op_a_q) * PROD_W'(op_b_q);

    // State and datapath registers; Reset aborts any operation in flight.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            cnt_q    <= '0;
            grant_q  <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            result_q <= result_d;
        end
    end

    // Next-state: grant and capture in IDLE, settle in WAIT, hand back in DONE.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (|bus.iReq) begin
                    state_d = WAIT;
                    grant_d = pick_gnt;
                    win_d   = pick_idx;
                    op_a_d  = bus.iA[int'(pick_idx)*OPND_W +: OPND_W];
                    op_b_d  = bus.iB[int'(pick_idx)*OPND_W +: OPND_W];
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d  = DONE;
                    result_d = product;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
`ifdef IMUL_ARB_FIXED_PRIO_EN
                // Pointer pinned at 0: lowest index always wins.
                ptr_d   = '0;
`else
                // Move priority just past the requester that was served.
                ptr_d   = (win_q == IDX_LAST) ? '0 : win_q + 1'b1;
`endif
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign bus.oGrant  = grant_q;
    assign bus.oDone   = (state_q == DONE) ? grant_q : '0;
    assign bus.oResult = result_q;
    assign bus.oBusy   = (state_q != IDLE);

endmodule
